dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
Multi-cycle data-memory bridge between the CPU core's MEM-stage RAM port (ce/we/addr/data/sel) and a handshaked data bus with variable latency.
It converts the core's single-cycle combinational RAM access into a req/ack bus transaction.
It holds the pipeline through ctrl via a stall request until the access completes.
It also provides a bus-timeout error flag.

Parameters:
ADDR_W, 32, CPU/bus address width
DATA_W, 32, data width; sel width is DATA_W/8
TIMEOUT, 255, max cycles waiting for bus_ack_i before forced completion (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cpu_ce_i  in  1  access request from MEM stage (held stable while stalled)
cpu_we_i  in  1  1=store, 0=load
cpu_addr_i  in  ADDR_W  byte address
cpu_data_i  in  DATA_W  store data
cpu_sel_i  in  DATA_W/8  byte enables
cpu_data_o  out  DATA_W  load data to MEM stage
stallreq_o  out  1  stall request to ctrl
bus_req_o  out  1  bus request
bus_we_o  out  1  bus write
bus_addr_o  out  ADDR_W  word-aligned address
bus_wdata_o  out  DATA_W  write data
bus_sel_o  out  DATA_W/8  byte enables
bus_ack_i  in  1  transfer complete
bus_rdata_i  in  DATA_W  read data, valid when bus_ack_i=1
err_o  out  1  sticky timeout flag

Behaviour:
- Single clock domain. Reset is asynchronous and active-low (rst=0 resets).
- All registered outputs are 0 during reset: cpu_data_o, bus_*, err_o. stallreq_o is 0 during reset. State is IDLE.
- FSM states and transitions:
  - IDLE: if cpu_ce_i=1, stallreq_o=1 combinationally in the same cycle. Capture we/addr/data/sel into internal regs, then go to REQ.
  - REQ: bus_req_o=1. bus_addr_o={addr[ADDR_W-1:2],2'b00}; bus_we_o, bus_wdata_o and bus_sel_o come from the captured regs and stay stable until ack. stallreq_o=1. The wait counter increments each cycle.
    - bus_ack_i=1: latch bus_rdata_i into cpu_data_o (loads only; stores leave it unchanged), then go to DONE.
    - counter==TIMEOUT-1 without ack: set err_o, cpu_data_o=0, drop bus_req_o, then go to DONE.
  - DONE: bus_req_o=0, stallreq_o=0, cpu_data_o holds. The pipeline advances at the end of this cycle. Next state is IDLE unconditionally.
- A back-to-back request appears in the following IDLE cycle and is treated as a new access. No request is ever re-issued from DONE.
- bus_ack_i is ignored whenever bus_req_o=0.
- An ack in the first REQ cycle is legal. Minimum latency is IDLE, REQ, DONE: 2 stalled cycles and data valid in the 3rd cycle.
- If cpu_ce_i falls during REQ, the bus transaction still completes (no withdrawal) and the result is discarded. The FSM goes through DONE normally.
- The counter clears on IDLE→REQ. It is wide enough for TIMEOUT (clog2).
- err_o is sticky until reset. Later accesses still proceed normally.
- Reset asserted mid-transaction immediately drops bus_req_o and returns to IDLE. The bus must tolerate the abandoned request.

Decomposition:
- Shared defines.v gets the FSM state encodings (`DmemIdle, `DmemReq, `DmemDone, 2-bit) and `DmemTimeoutDefault.
- No sub-module is required. The timeout counter stays inline.
- ctrl gains a stallreq_from_mem input driven by stallreq_o.

Test Plan:
- Load, ack on first REQ cycle: cpu_ce=1, we=0, addr=0x104, bus_rdata=0xDEADBEEF → bus_addr=0x104, stall high for 2 cycles, cpu_data_o=0xDEADBEEF in DONE, err_o=0.
- Store with 5-cycle ack delay: addr=0x203, data=0x11223344, sel=4'b0010 → bus_addr=0x200, bus_we=1, signals stable 5 cycles, stall high for 6 cycles, cpu_data_o unchanged.
- Timeout with TIMEOUT=4, no ack → bus_req high 4 cycles then low, err_o=1 and stays 1, cpu_data_o=0. A following load with ack completes with correct data.
- Back-to-back: load 0x10 (ack delay 0) then load 0x14 (ack delay 2) → two distinct bus transactions, one DONE cycle between them, data 0xA then 0xB.
- Spurious ack in IDLE and rst=0 during REQ → no state change from the ack. Reset forces bus_req_o=0, stallreq_o=0, IDLE. After release, the next access completes normally.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM state
// encodings, default bus timeout and counter sizing helper.
package dmem_bridge_pkg;

    // Bridge FSM states (2-bit encoding shared with ctrl/debug).
    typedef enum logic [1:0] {
        DmemIdle = 2'b00,
        DmemReq  = 2'b01,
        DmemDone = 2'b10
    } dmem_state_e;

    localparam int DmemTimeoutDefault = 255;

    // Counter holds 0..t-1, so clog2(t) bits suffice (min 1 bit).
    function automatic int cnt_width(input int t);
        return (t < 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Handshaked data bus between the bridge (master) and memory
// (slave): req/we/addr/wdata/sel out, ack/rdata back.
interface dmem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   sel;
    logic                  ack;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        output sel,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        input  sel,
        output ack,
        output rdata
    );

endinterface

// File: rtl/dmem_bridge.sv
// MEM-stage RAM port to req/ack bus bridge with pipeline stall
// and sticky bus-timeout flag.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   cpu_ce_i        access request (held while stalled)
//   cpu_we_i        1=store, 0=load
//   cpu_addr_i      byte address
//   cpu_data_i      store data
//   cpu_sel_i       byte enables
//   cpu_data_o      load data (valid in DONE)
//   stallreq_o      stall request to ctrl
//   bus             dmem_bridge_if master side
//   err_o           sticky timeout flag
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DmemTimeoutDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_ce_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq_o,
    dmem_bridge_if.master       bus,
    output logic                err_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    dmem_state_e state_q;
    dmem_state_e state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    logic stall;
    logic start;
    logic ack_hit;
    logic tmo_hit;

    // Byte offset is dropped: the bus is word addressed.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        start   = 1'b0;
        ack_hit = 1'b0;
        tmo_hit = 1'b0;
        unique case (state_q)
            DmemIdle: begin
                if (cpu_ce_i) begin
                    stall   = 1'b1;
                    start   = 1'b1;
                    state_d = DmemReq;
                end
            end
            DmemReq: begin
                stall = 1'b1;
                if (bus.ack && req_q) begin
                    ack_hit = 1'b1;
                    state_d = DmemDone;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = DmemDone;
                end
            end
            DmemDone: begin
                state_d = DmemIdle;
            end
            default: begin
                state_d = DmemIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DmemIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (start) begin
                cnt_q   <= '0;
                req_q   <= 1'b1;
                we_q    <= cpu_we_i;
                addr_q  <= {cpu_addr_i[ADDR_W-1:2], 2'b00};
                wdata_q <= cpu_data_i;
                sel_q   <= cpu_sel_i;
            end else if (state_q == DmemReq) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (ack_hit) begin
                req_q <= 1'b0;
                if (!we_q) begin
                    data_q <= bus.rdata;
                end
            end
            // Forced completion: flag and return zero data.
            if (tmo_hit) begin
                req_q  <= 1'b0;
                err_q  <= 1'b1;
                data_q <= '0;
            end
        end
    end

    // Gated by rst so ctrl never sees a stall during reset.
    assign stallreq_o = rst & stall;
    assign cpu_data_o = data_q;
    assign err_o      = err_q;

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.sel   = sel_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: two instances
// (default timeout and TIMEOUT=4) driven by directed accesses.
module tb_dmem_bridge;

    localparam int TMO_A = 255;
    localparam int TMO_B = 4;

    logic clk;
    logic rst;

    logic        ce[2];
    logic        we[2];
    logic [31:0] addr[2];
    logic [31:0] wd[2];
    logic [3:0]  sel[2];
    logic        ack[2];
    logic [31:0] rdata[2];

    logic [31:0] cd[2];
    logic        st[2];
    logic        er[2];
    logic        rq[2];
    logic        bwe[2];
    logic [31:0] ba[2];
    logic [31:0] bwd[2];
    logic [3:0]  bsel[2];

    logic        e_stall[2];
    logic        e_req[2];
    logic        e_bus[2];
    logic        e_we[2];
    logic [31:0] e_addr[2];
    logic [31:0] e_wdata[2];
    logic [3:0]  e_sel[2];
    logic [31:0] e_data[2];
    logic        e_err[2];

    logic chk_en;
    int   n_pass;
    int   n_total;

    int          sc[2];
    int          rc[2];
    int          tx[2];
    logic [31:0] la[2];
    logic        prev_rq[2];

    dmem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    dmem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

    assign bus_a.ack   = ack[0];
    assign bus_a.rdata = rdata[0];
    assign bus_b.ack   = ack[1];
    assign bus_b.rdata = rdata[1];

    assign rq[0]   = bus_a.req;
    assign bwe[0]  = bus_a.we;
    assign ba[0]   = bus_a.addr;
    assign bwd[0]  = bus_a.wdata;
    assign bsel[0] = bus_a.sel;
    assign rq[1]   = bus_b.req;
    assign bwe[1]  = bus_b.we;
    assign ba[1]   = bus_b.addr;
    assign bwd[1]  = bus_b.wdata;
    assign bsel[1] = bus_b.sel;

    dmem_bridge #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO_A)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .cpu_ce_i  (ce[0]),
        .cpu_we_i  (we[0]),
        .cpu_addr_i(addr[0]),
        .cpu_data_i(wd[0]),
        .cpu_sel_i (sel[0]),
        .cpu_data_o(cd[0]),
        .stallreq_o(st[0]),
        .bus       (bus_a),
        .err_o     (er[0])
    );

    dmem_bridge #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO_B)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .cpu_ce_i  (ce[1]),
        .cpu_we_i  (we[1]),
        .cpu_addr_i(addr[1]),
        .cpu_data_i(wd[1]),
        .cpu_sel_i (sel[1]),
        .cpu_data_o(cd[1]),
        .stallreq_o(st[1]),
        .bus       (bus_b),
        .err_o     (er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] at %0t: got %h expected %h",
                      nm, i, $time, act, exp);
    endtask

    // Per-cycle comparison against the expectation model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("stall", i, 32'(st[i]), 32'(e_stall[i]));
                chk("req", i, 32'(rq[i]), 32'(e_req[i]));
                chk("cpu_data", i, cd[i], e_data[i]);
                chk("err", i, 32'(er[i]), 32'(e_err[i]));
                if (e_bus[i]) begin
                    chk("bus_we", i, 32'(bwe[i]), 32'(e_we[i]));
                    chk("bus_addr", i, ba[i], e_addr[i]);
                    chk("bus_wdata", i, bwd[i], e_wdata[i]);
                    chk("bus_sel", i, 32'(bsel[i]), 32'(e_sel[i]));
                end
            end
        end
    end

    // Activity counters used by the literal checks.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (st[i] === 1'b1) sc[i]++;
            if (rq[i] === 1'b1) begin
                rc[i]++;
                la[i] = ba[i];
                if (!prev_rq[i]) tx[i]++;
            end
            prev_rq[i] = (rq[i] === 1'b1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle(input int i);
        ce[i]      = 1'b0;
        ack[i]     = 1'b0;
        e_stall[i] = 1'b0;
        e_req[i]   = 1'b0;
        e_bus[i]   = 1'b0;
    endtask

    task automatic exp_reset();
        for (int i = 0; i < 2; i++) begin
            e_stall[i] = 1'b0;
            e_req[i]   = 1'b0;
            e_bus[i]   = 1'b1;
            e_we[i]    = 1'b0;
            e_addr[i]  = '0;
            e_wdata[i] = '0;
            e_sel[i]   = '0;
            e_data[i]  = '0;
            e_err[i]   = 1'b0;
        end
    endtask

    // One CPU access: IDLE cycle, REQ cycles, DONE cycle.
    // waits = REQ cycles without ack before the ack cycle.
    task automatic run_access(input int i, input logic w,
                              input logic [31:0] a,
                              input logic [31:0] d,
                              input logic [3:0] s,
                              input int waits, input logic give_ack,
                              input logic [31:0] rd);
        int tmo;
        int len;
        tmo = (i == 0) ? TMO_A : TMO_B;
        len = give_ack ? waits + 1 : tmo;
        ce[i]   = 1'b1;
        we[i]   = w;
        addr[i] = a;
        wd[i]   = d;
        sel[i]  = s;
        ack[i]  = 1'b0;
        e_stall[i] = 1'b1;
        e_req[i]   = 1'b0;
        e_bus[i]   = 1'b0;
        step();
        for (int k = 1; k <= len; k++) begin
            ack[i]     = give_ack && (k == len);
            rdata[i]   = (k == len) ? rd : (32'hBAD0_0000 | 32'(k));
            e_stall[i] = 1'b1;
            e_req[i]   = 1'b1;
            e_bus[i]   = 1'b1;
            e_we[i]    = w;
            e_addr[i]  = a & 32'hFFFF_FFFC;
            e_wdata[i] = d;
            e_sel[i]   = s;
            step();
        end
        // Stray ack in DONE must be ignored.
        ack[i]     = 1'b1;
        rdata[i]   = 32'h7777_7777;
        e_stall[i] = 1'b0;
        e_req[i]   = 1'b0;
        e_bus[i]   = 1'b0;
        if (!give_ack) begin
            e_data[i] = '0;
            e_err[i]  = 1'b1;
        end else if (!w) begin
            e_data[i] = rd;
        end
        step();
        set_idle(i);
    endtask

    initial begin
        int s0;
        int r0;
        int t0;
        n_pass  = 0;
        n_total = 0;
        chk_en  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sc[i] = 0;
            rc[i] = 0;
            tx[i] = 0;
            la[i] = '0;
            prev_rq[i] = 1'b0;
            ce[i] = 1'b0;
            we[i] = 1'b0;
            addr[i] = '0;
            wd[i] = '0;
            sel[i] = '0;
            ack[i] = 1'b0;
            rdata[i] = '0;
        end
        exp_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;
        ce[0] = 1'b1;
        ce[1] = 1'b1;
        step();
        chk("rst_stall_gate", 0, 32'(st[0]), 32'd0);
        chk("rst_data", 0, cd[0], 32'h0);
        step();
        rst = 1'b1;
        set_idle(0);
        set_idle(1);
        step();

        ack[0]   = 1'b1;
        rdata[0] = 32'hFFFF_FFFF;
        step();
        set_idle(0);
        step();
        chk("spurious_ack_data", 0, cd[0], 32'h0);

        s0 = sc[0];
        run_access(0, 1'b0, 32'h104, 32'h0, 4'hF, 0, 1'b1,
                   32'hDEAD_BEEF);
        chk("load_stall_cycles", 0, 32'(sc[0] - s0), 32'd2);
        chk("load_data", 0, cd[0], 32'hDEAD_BEEF);
        chk("load_addr", 0, la[0], 32'h104);
        chk("load_err", 0, 32'(er[0]), 32'd0);

        s0 = sc[0];
        r0 = rc[0];
        run_access(0, 1'b1, 32'h203, 32'h1122_3344, 4'b0010, 4,
                   1'b1, 32'hCAFE_F00D);
        chk("store_stall_cycles", 0, 32'(sc[0] - s0), 32'd6);
        chk("store_req_cycles", 0, 32'(rc[0] - r0), 32'd5);
        chk("store_addr", 0, la[0], 32'h200);
        chk("store_data_kept", 0, cd[0], 32'hDEAD_BEEF);

        run_access(1, 1'b0, 32'h308, 32'h0, 4'hF, 0, 1'b1,
                   32'h55AA_55AA);
        chk("b_load_data", 1, cd[1], 32'h55AA_55AA);
        r0 = rc[1];
        run_access(1, 1'b0, 32'h300, 32'h0, 4'hF, 0, 1'b0, 32'h0);
        chk("tmo_req_cycles", 1, 32'(rc[1] - r0), 32'd4);
        chk("tmo_err", 1, 32'(er[1]), 32'd1);
        chk("tmo_data", 1, cd[1], 32'h0);
        step();
        step();
        chk("tmo_err_sticky", 1, 32'(er[1]), 32'd1);
        run_access(1, 1'b0, 32'h30C, 32'h0, 4'hF, 1, 1'b1,
                   32'h0F0F_0F0F);
        chk("after_tmo_data", 1, cd[1], 32'h0F0F_0F0F);
        chk("after_tmo_err", 1, 32'(er[1]), 32'd1);

        t0 = tx[0];
        run_access(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b1, 32'hA);
        chk("b2b_first", 0, cd[0], 32'hA);
        run_access(0, 1'b0, 32'h14, 32'h0, 4'hF, 2, 1'b1, 32'hB);
        chk("b2b_second", 0, cd[0], 32'hB);
        chk("b2b_txns", 0, 32'(tx[0] - t0), 32'd2);
        chk("b2b_last_addr", 0, la[0], 32'h14);

        ce[0]   = 1'b1;
        we[0]   = 1'b0;
        addr[0] = 32'h80;
        sel[0]  = 4'hF;
        e_stall[0] = 1'b1;
        step();
        e_req[0]   = 1'b1;
        e_bus[0]   = 1'b1;
        e_we[0]    = 1'b0;
        e_addr[0]  = 32'h80;
        e_wdata[0] = wd[0];
        e_sel[0]   = 4'hF;
        step();
        exp_reset();
        rst = 1'b0;
        #1;
        chk("rst_mid_req", 0, 32'(rq[0]), 32'd0);
        chk("rst_mid_stall", 0, 32'(st[0]), 32'd0);
        step();
        step();
        rst = 1'b1;
        set_idle(0);
        set_idle(1);
        step();
        chk("rst_clears_err", 1, 32'(er[1]), 32'd0);
        run_access(0, 1'b0, 32'h40, 32'h0, 4'hF, 1, 1'b1,
                   32'h1234_5678);
        chk("post_rst_data", 0, cd[0], 32'h1234_5678);
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
